ssd_scan: RTL and testbench
===========================

Name: ssd_scan

Overview:
- Multiplexed seven-segment display driver. It sits directly downstream of the cascaded dch/uch digit counters.
- It takes DIGITS packed 4-bit digit values, decodes each to hex 7-segment form, and scans one active-low anode at a time at a programmable refresh rate.
- Digits are snapshotted once per scan frame, so counter updates mid-frame never tear the display.

Parameters:
- DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 100000, clock cycles each digit is lit (>=2).

Ports:
- ssd_clk  input  1  system clock.
- ssd_rst  input  1  asynchronous reset, active-high.
- ssd_en  input  1  scan enable; low blanks the display.
- ssd_din  input  DIGITS*4  packed digits; digit k = ssd_din[4k+3:4k]; digit 0 is rightmost.
- ssd_dp_in  input  DIGITS  decimal-point request per digit, active-high.
- ssd_seg  output  7  segments gfedcba, active-low, registered.
- ssd_dp  output  1  decimal point, active-low, registered.
- ssd_an  output  DIGITS  anode enables, active-low, one-hot-low, registered.
- ssd_frame  output  1  one-cycle pulse when the scan wraps back to digit 0, registered.

Behaviour:
- Reset (async, active-high): all state is cleared immediately, independent of the clock.
  - prescaler=0, idx=0, snapshot=0.
  - ssd_seg=7'b1111111, ssd_dp=1, ssd_an=all ones, ssd_frame=0.
- Reset mid-frame: same values apply immediately. After release, the scan restarts at digit 0 with a full REFRESH_DIV dwell.
- Prescaler: counts 0..REFRESH_DIV-1 while ssd_en=1. Terminal count (tc) is prescaler==REFRESH_DIV-1; at tc it wraps to 0.
- Index: at tc, idx advances. Digit DIGITS-1 wraps to 0; otherwise idx+1.
- Snapshot:
  - Loaded from {ssd_din, ssd_dp_in} on the tc cycle where idx==DIGITS-1, i.e. together with the wrap to 0.
  - While ssd_en=0 the snapshot loads every clock, so display content is fresh on enable.
  - Between loads it holds; changes on ssd_din mid-frame are ignored until the next wrap.
- Frame pulse: ssd_frame=1 for exactly the one cycle after the wrap tc, else 0.
- Output stage: registered from current idx and snapshot, giving 1 clock latency. ssd_an changes on the clock after idx changes.
  - ssd_an: bit idx low, all other bits high.
  - ssd_seg: decode of snapshot digit idx.
  - ssd_dp: inverse of snapshot dp bit idx.
- Decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - All 16 codes are decoded; there are no illegal values.
- ssd_en=0:
  - prescaler and idx are forced to 0; ssd_frame=0.
  - Registered outputs go blank next clock: an all ones, seg all ones, dp=1.
- ssd_en rising: the digit 0 anode is lit on the 2nd clock after ssd_en is sampled high. It dwells REFRESH_DIV cycles.
- ssd_en falling mid-dwell: outputs blank on the next clock; no partial frame pulse.
- Simultaneous events: reset has priority over ssd_en, and ssd_en has priority over tc.
- Scan order is strictly 0,1,...,DIGITS-1,0. Exactly one anode is low at any time while enabled.

Optional Feature:
- Macro: SSD_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit k (k>=1) is blanked when it and all higher snapshot digits are 0 and its dp bit is 0. Blanked means anode stays high during its slot; timing is unchanged.
  - Digit 0 is never blanked.
- Undefined: every digit is always lit, and zeros display as "0".

Test Plan:
- Reset/blank: assert ssd_rst mid-dwell, asynchronously between clock edges, with DIGITS=4, REFRESH_DIV=4 → outputs go immediately to an=1111, seg=1111111, dp=1, frame=0.
- Scan timing: en=1, ssd_din=16'h4321 → an sequence 1110,1101,1011,0111, each held 4 clocks; seg 1111001, 0100100, 0110000, 0011001; frame pulses every 16 clocks.
- No tearing: change ssd_din from 16'h4321 to 16'h9999 while idx=1 → remaining digits of the current frame still show 2,3,4; 9s appear only from the next digit-0 slot.
- Enable gating: drop en for 3 clocks mid-frame → blank next clock; on re-enable, digit 0 is lit on the 2nd clock with a full 4-cycle dwell; no frame pulse during the gap.
- Decode sweep: step digit 0 through 0..F with dp_in[0]=1 → seg matches the table for every code; dp=0 only while an[0] is low.
- With SSD_LZ_BLANK_EN: ssd_din=16'h0070 → an[3] and an[2] stay high in their slots; digit 1 shows 7 (1111000); digit 0 shows 0. Without the macro, all four digits light.

Source files
------------

// File: rtl/ssd_scan_if.sv
// Display-side bundle for ssd_scan: scan controls and digit data in,
// registered active-low segment/anode drive and frame pulse out.
interface ssd_scan_if #(
  parameter int DIGITS = 4
);
  logic                  ssd_en;
  logic [DIGITS*4-1:0]   ssd_din;
  logic [DIGITS-1:0]     ssd_dp_in;
  logic [6:0]            ssd_seg;
  logic                  ssd_dp;
  logic [DIGITS-1:0]     ssd_an;
  logic                  ssd_frame;

  modport master (
    output ssd_en, ssd_din, ssd_dp_in,
    input  ssd_seg, ssd_dp, ssd_an, ssd_frame
  );

  modport slave (
    input  ssd_en, ssd_din, ssd_dp_in,
    output ssd_seg, ssd_dp, ssd_an, ssd_frame
  );
endinterface

// File: rtl/ssd_scan.sv
// Multiplexed hex seven-segment scanner with per-frame digit snapshot.
// Optional leading-zero blanking is enabled by defining SSD_LZ_BLANK_EN.
module ssd_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       ssd_clk,
  input  logic       ssd_rst,
  ssd_scan_if.slave  bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic                 en_q;
  logic [PW-1:0]        presc_q, presc_nxt;
  logic [IW-1:0]        idx_q, idx_nxt;
  logic [DIGITS*4-1:0]  snap_din_q;
  logic [DIGITS-1:0]    snap_dp_q;
  logic                 snap_ld;
  logic [6:0]           seg_q, seg_nxt;
  logic                 dp_q, dp_nxt;
  logic [DIGITS-1:0]    an_q, an_nxt;
  logic                 frame_q, frame_nxt;
  logic                 run, tc, wrap;
  logic [3:0]           digit_sel;
  logic                 dp_sel;
  logic                 lz_sel;
  logic [DIGITS-1:0]    lz_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

`ifdef SSD_LZ_BLANK_EN
  logic lz_zero;
  // A digit is a leading zero only if every digit from it upward is zero.
  always_comb begin
    lz_blank = '0;
    lz_zero  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lz_zero     = lz_zero & (snap_din_q[4*k +: 4] == 4'h0);
      lz_blank[k] = lz_zero & ~snap_dp_q[k];
    end
  end
`else
  always_comb begin
    lz_blank = '0;
  end
`endif

  always_comb begin
    digit_sel = '0;
    dp_sel    = 1'b0;
    lz_sel    = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        digit_sel = snap_din_q[4*k +: 4];
        dp_sel    = snap_dp_q[k];
        lz_sel    = lz_blank[k];
      end
    end
  end

  // Scanning starts one clock after enable is seen, so the first digit-0 dwell is full length.
  always_comb begin
    run       = bus.ssd_en & en_q;
    tc        = (presc_q == PRE_LAST);
    wrap      = tc & (idx_q == IDX_LAST);
    presc_nxt = '0;
    idx_nxt   = '0;
    snap_ld   = 1'b1;
    frame_nxt = 1'b0;
    an_nxt    = '1;
    seg_nxt   = '1;
    dp_nxt    = 1'b1;
    if (run) begin
      presc_nxt = tc ? '0 : presc_q + PW'(1);
      if (tc) begin
        idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        idx_nxt = idx_q;
      end
      snap_ld   = wrap;
      frame_nxt = wrap;
      if (!lz_sel) begin
        an_nxt  = ~(DIGITS'(1) << idx_q);
        seg_nxt = seg_decode(digit_sel);
        dp_nxt  = ~dp_sel;
      end
    end
  end

  always_ff @(posedge ssd_clk or posedge ssd_rst) begin
    if (ssd_rst) begin
      en_q       <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      snap_din_q <= '0;
      snap_dp_q  <= '0;
      seg_q      <= '1;
      dp_q       <= 1'b1;
      an_q       <= '1;
      frame_q    <= 1'b0;
    end else begin
      en_q    <= bus.ssd_en;
      presc_q <= presc_nxt;
      idx_q   <= idx_nxt;
      if (snap_ld) begin
        snap_din_q <= bus.ssd_din;
        snap_dp_q  <= bus.ssd_dp_in;
      end
      seg_q   <= seg_nxt;
      dp_q    <= dp_nxt;
      an_q    <= an_nxt;
      frame_q <= frame_nxt;
    end
  end

  assign bus.ssd_seg   = seg_q;
  assign bus.ssd_dp    = dp_q;
  assign bus.ssd_an    = an_q;
  assign bus.ssd_frame = frame_q;
endmodule

// File: tb/tb_ssd_scan.sv
// Bench for ssd_scan: directed scan/tearing/enable/decode/reset cases, then
// randomized traffic, all checked against a frame-level display model.
module tb_ssd_scan;
  localparam int D  = 4;
  localparam int R  = 4;
  localparam int FR = D * R;

  logic ssd_clk = 1'b0;
  logic ssd_rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  ssd_scan_if #(.DIGITS(D)) bus ();

  ssd_scan #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .ssd_clk (ssd_clk),
    .ssd_rst (ssd_rst),
    .bus     (bus)
  );

  always #5 ssd_clk = ~ssd_clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [3:0] lit_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] lit_seg [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: display is lit from the 2nd consecutive enabled edge; n counts lit cycles.
  // Each frame shows the digits sampled on the edge just before that frame began.
  int         run_len = 0;
  int         n, dg;
  logic [15:0] prev_din = '0, frame_din = '0;
  logic [3:0]  prev_dp = '0, frame_dp = '0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fr;

  always @(posedge ssd_clk or posedge ssd_rst) begin
    if (ssd_rst) begin
      run_len = 0;
    end else begin
      run_len = bus.ssd_en ? run_len + 1 : 0;
      e_an  = '1;
      e_seg = '1;
      e_dp  = 1'b1;
      e_fr  = 1'b0;
      if (run_len >= 2) begin
        n = run_len - 2;
        if (n % FR == 0) begin
          frame_din = prev_din;
          frame_dp  = prev_dp;
        end
        dg    = (n / R) % D;
        e_an  = ~(4'b0001 << dg);
        e_seg = seg_tab[frame_din[4*dg +: 4]];
        e_dp  = ~frame_dp[dg];
        e_fr  = (n % FR == FR - 1);
`ifdef SSD_LZ_BLANK_EN
        if (dg >= 1 && (frame_din >> (4*dg)) == 16'h0 && !frame_dp[dg]) begin
          e_an  = '1;
          e_seg = '1;
          e_dp  = 1'b1;
        end
`endif
      end
      prev_din = bus.ssd_din;
      prev_dp  = bus.ssd_dp_in;
      #1;
      chk("model_an",    32'(bus.ssd_an),    32'(e_an));
      chk("model_seg",   32'(bus.ssd_seg),   32'(e_seg));
      chk("model_dp",    32'(bus.ssd_dp),    32'(e_dp));
      chk("model_frame", 32'(bus.ssd_frame), 32'(e_fr));
    end
  end

  initial begin
    bus.ssd_en    = 1'b0;
    bus.ssd_din   = '0;
    bus.ssd_dp_in = '0;
    repeat (3) @(negedge ssd_clk);

    // Scan timing with 4321
    ssd_rst     = 1'b0;
    bus.ssd_en  = 1'b1;
    bus.ssd_din = 16'h4321;
    @(posedge ssd_clk); #2;
    chk("start_blank_an", 32'(bus.ssd_an), 32'hF);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge ssd_clk); #2;
        chk("scan_an",    32'(bus.ssd_an),    32'(lit_an[d]));
        chk("scan_seg",   32'(bus.ssd_seg),   32'(lit_seg[d]));
        chk("scan_frame", 32'(bus.ssd_frame), 32'(d == 3 && c == 3));
      end
    end

    // No tearing: change data during the digit-1 slot of the second frame
    repeat (5) @(posedge ssd_clk);
    @(negedge ssd_clk);
    bus.ssd_din = 16'h9999;
    repeat (4) @(posedge ssd_clk); #2;
    chk("tear_d2_an",  32'(bus.ssd_an),  32'b1011);
    chk("tear_d2_seg", 32'(bus.ssd_seg), 32'b0110000);
    repeat (4) @(posedge ssd_clk); #2;
    chk("tear_d3_seg", 32'(bus.ssd_seg), 32'b0011001);
    repeat (4) @(posedge ssd_clk); #2;
    chk("tear_new_an",  32'(bus.ssd_an),  32'b1110);
    chk("tear_new_seg", 32'(bus.ssd_seg), 32'b0010000);

    // Enable gap of 3 clocks
    @(negedge ssd_clk);
    bus.ssd_en = 1'b0;
    repeat (3) begin
      @(posedge ssd_clk); #2;
      chk("gap_an",    32'(bus.ssd_an),    32'hF);
      chk("gap_frame", 32'(bus.ssd_frame), 32'h0);
    end
    @(negedge ssd_clk);
    bus.ssd_en = 1'b1;
    @(posedge ssd_clk); #2;
    chk("reen_1st_an", 32'(bus.ssd_an), 32'hF);
    @(posedge ssd_clk); #2;
    chk("reen_2nd_an",  32'(bus.ssd_an),  32'b1110);
    chk("reen_2nd_seg", 32'(bus.ssd_seg), 32'b0010000);
    repeat (3) @(posedge ssd_clk); #2;
    chk("reen_dwell_an", 32'(bus.ssd_an), 32'b1110);
    @(posedge ssd_clk); #2;
    chk("reen_next_an", 32'(bus.ssd_an), 32'b1101);

    // Decode sweep on digit 0 with its decimal point requested
    for (int k = 0; k < 16; k++) begin
      @(negedge ssd_clk);
      bus.ssd_din   = {12'h123, 4'(k)};
      bus.ssd_dp_in = 4'b0001;
      repeat (FR) @(posedge ssd_clk);
    end

    // Asynchronous reset between edges, mid-dwell
    @(posedge ssd_clk); #3;
    ssd_rst = 1'b1;
    #1;
    chk("arst_an",    32'(bus.ssd_an),    32'hF);
    chk("arst_seg",   32'(bus.ssd_seg),   32'h7F);
    chk("arst_dp",    32'(bus.ssd_dp),    32'h1);
    chk("arst_frame", 32'(bus.ssd_frame), 32'h0);

    // Leading zeros: 0070
    @(negedge ssd_clk);
    ssd_rst       = 1'b0;
    bus.ssd_din   = 16'h0070;
    bus.ssd_dp_in = 4'b0000;
    @(posedge ssd_clk); #2;
    chk("lz_start_an", 32'(bus.ssd_an), 32'hF);
    @(posedge ssd_clk); #2;
    chk("lz_d0_an",  32'(bus.ssd_an),  32'b1110);
    chk("lz_d0_seg", 32'(bus.ssd_seg), 32'b1000000);
    repeat (4) @(posedge ssd_clk); #2;
    chk("lz_d1_an",  32'(bus.ssd_an),  32'b1101);
    chk("lz_d1_seg", 32'(bus.ssd_seg), 32'b1111000);
    repeat (4) @(posedge ssd_clk); #2;
`ifdef SSD_LZ_BLANK_EN
    chk("lz_d2_an", 32'(bus.ssd_an), 32'b1111);
`else
    chk("lz_d2_an", 32'(bus.ssd_an), 32'b1011);
`endif
    repeat (4) @(posedge ssd_clk); #2;
`ifdef SSD_LZ_BLANK_EN
    chk("lz_d3_an", 32'(bus.ssd_an), 32'b1111);
`else
    chk("lz_d3_an", 32'(bus.ssd_an), 32'b0111);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge ssd_clk);
      if (ssd_rst) ssd_rst = 1'b0;
      else if ($urandom_range(0, 599) == 0) ssd_rst = 1'b1;
      bus.ssd_en = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 9) == 0)
        bus.ssd_din = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        bus.ssd_dp_in = 4'($urandom);
    end
    @(negedge ssd_clk);
    ssd_rst = 1'b0;
    repeat (4) @(posedge ssd_clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
